// File: rtl/ring_pkg.sv
// Shared ring definitions: decoder FSM states and the rotation rule.
// Used by the ring counter and by ring_decoder.
package ring_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } ring_state_e;

    // Ring rotates toward lower bit positions: k -> (k + n - 1) mod n.
    function automatic int unsigned ring_next_idx(input int unsigned k, input int unsigned n);
        return (k + n - 1) % n;
    endfunction

endpackage : ring_pkg

// File: rtl/ring_onehot_enc.sv
// One-hot detector and binary encoder for an N-bit ring sample.
// Ports: vec_i (sample), is_onehot_o (exactly one bit set), idx_o (position of
// the set bit; meaningful only when is_onehot_o is high).
module ring_onehot_enc #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         vec_i,
    output logic                 is_onehot_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int unsigned IW = $clog2(N);

    logic seen;
    logic multi;

    // Scan all bits: track whether any and more than one are set.
    always_comb begin
        seen  = 1'b0;
        multi = 1'b0;
        idx_o = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (vec_i[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen  = 1'b1;
                idx_o = IW'(i);
            end
        end
        is_onehot_o = seen && !multi;
    end

endmodule : ring_onehot_enc

// File: rtl/ring_decoder.sv
// Ring pattern decoder: tracks a rotating one-hot ring, locks after LOCK_CNT
// consecutive correct steps, flags loss of lock and counts revolutions.
// Ports: clk, rstn (sync active-low), ring_in/ring_vld (qualified sample),
// idx (last one-hot position), locked, err (loss-of-lock pulse), err_cnt
// (saturating), rev_pulse (revolution pulse), rev_cnt (wrapping).
module ring_decoder
    import ring_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned REV_W    = 8,
    parameter int unsigned ERR_W    = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N-1:0]         ring_in,
    input  logic                 ring_vld,
    output logic [$clog2(N)-1:0] idx,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_W-1:0]     err_cnt,
    output logic                 rev_pulse,
    output logic [REV_W-1:0]     rev_cnt
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = $clog2(LOCK_CNT + 1);

    ring_state_e      state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             rev_pulse_q, rev_pulse_d;
    logic [REV_W-1:0] rev_cnt_q, rev_cnt_d;

    logic             is_onehot;
    logic [IW-1:0]    enc_idx;
    logic [IW-1:0]    exp_idx;
    logic             at_exp;
    logic [CW-1:0]    cnt_inc;

    ring_onehot_enc #(.N(N)) u_enc (
        .vec_i       (ring_in),
        .is_onehot_o (is_onehot),
        .idx_o       (enc_idx)
    );

    assign exp_idx = IW'(ring_next_idx(32'(idx_q), N));
    assign at_exp  = is_onehot && (enc_idx == exp_idx);
    assign cnt_inc = cnt_q + CW'(1);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= HUNT;
            idx_q       <= '0;
            cnt_q       <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            rev_pulse_q <= 1'b0;
            rev_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            rev_pulse_q <= rev_pulse_d;
            rev_cnt_q   <= rev_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (ring_vld) begin
            case (state_q)
                HUNT: begin
                    if (is_onehot) begin
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (!is_onehot) begin
                        state_d = HUNT;
                    end else if (at_exp && (cnt_inc == CW'(LOCK_CNT))) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (!at_exp) begin
                        state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Datapath and output next values; pulses drop whenever no sample arrives.
    always_comb begin
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        locked_d    = locked_q;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
        rev_pulse_d = 1'b0;
        rev_cnt_d   = rev_cnt_q;
        if (ring_vld) begin
            locked_d = (state_d == LOCKED);
            case (state_q)
                HUNT: begin
                    if (is_onehot) begin
                        idx_d = enc_idx;
                        cnt_d = '0;
                    end
                end
                SYNC: begin
                    if (is_onehot) begin
                        idx_d = enc_idx;
                        cnt_d = at_exp ? cnt_inc : '0;
                    end
                end
                LOCKED: begin
                    if (at_exp) begin
                        idx_d = enc_idx;
                        if (enc_idx == '0) begin
                            rev_pulse_d = 1'b1;
                            rev_cnt_d   = rev_cnt_q + REV_W'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt_q != {ERR_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign idx       = idx_q;
    assign locked    = locked_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
    assign rev_pulse = rev_pulse_q;
    assign rev_cnt   = rev_cnt_q;

endmodule : ring_decoder

// File: tb/tb_ring_decoder.sv
module tb_ring_decoder;
    import ring_pkg::*;

    logic       clk;
    logic       rstn;
    logic [3:0] ring_in;
    logic       ring_vld;
    logic [1:0] idx;
    logic       locked;
    logic       err;
    logic [1:0] err_cnt;
    logic       rev_pulse;
    logic [7:0] rev_cnt;

    int checks = 0;
    int errors = 0;

    ring_decoder #(.N(4), .LOCK_CNT(3), .REV_W(8), .ERR_W(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ring_in   (ring_in),
        .ring_vld  (ring_vld),
        .idx       (idx),
        .locked    (locked),
        .err       (err),
        .err_cnt   (err_cnt),
        .rev_pulse (rev_pulse),
        .rev_cnt   (rev_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // One qualified sample; outputs are observed 1 time unit after the edge.
    task automatic step(input logic [3:0] v);
        ring_in  = v;
        ring_vld = 1'b1;
        @(posedge clk);
        #1;
        ring_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        ring_vld = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input ring_state_e s);
        check(tag, 32'(dut.state_q), 32'(s));
    endtask

    initial begin
        rstn     = 1'b0;
        ring_in  = 4'b0000;
        ring_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_idx", 32'(idx), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_err", 32'(err), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        check("rst_rev_pulse", 32'(rev_pulse), 0);
        check("rst_rev_cnt", 32'(rev_cnt), 0);
        check_state("rst_state", HUNT);
        rstn = 1'b1;

        // Basic lock and first revolution.
        step(4'b0001);
        check_state("s1_state", SYNC);
        check("s1_idx", 32'(idx), 0);
        check("s1_locked", 32'(locked), 0);
        step(4'b1000);
        check("s2_idx", 32'(idx), 3);
        step(4'b0100);
        check("s3_idx", 32'(idx), 2);
        check("s3_locked", 32'(locked), 0);
        step(4'b0010);
        check("lock_idx", 32'(idx), 1);
        check("lock_locked", 32'(locked), 1);
        check("lock_rev_pulse", 32'(rev_pulse), 0);
        step(4'b0001);
        check("rev1_pulse", 32'(rev_pulse), 1);
        check("rev1_cnt", 32'(rev_cnt), 1);
        check("rev1_idx", 32'(idx), 0);
        idle(1);
        check("rev1_pulse_drop", 32'(rev_pulse), 0);

        // Long gap while locked keeps everything frozen.
        idle(50);
        check("gap_locked", 32'(locked), 1);
        check("gap_err", 32'(err), 0);
        check("gap_idx", 32'(idx), 0);
        check("gap_rev_cnt", 32'(rev_cnt), 1);
        step(4'b1000);
        check("gap_step_idx", 32'(idx), 3);
        check("gap_step_locked", 32'(locked), 1);

        // Error 1: non-one-hot while locked at idx 3.
        step(4'b0011);
        check("e1_err", 32'(err), 1);
        check("e1_err_cnt", 32'(err_cnt), 1);
        check("e1_locked", 32'(locked), 0);
        check("e1_idx", 32'(idx), 3);
        check_state("e1_state", HUNT);
        idle(1);
        check("e1_err_drop", 32'(err), 0);

        // Relock, then revolution to idx 0.
        step(4'b0001);
        step(4'b1000);
        step(4'b0100);
        step(4'b0010);
        check("rl1_locked", 32'(locked), 1);
        step(4'b0001);
        check("rev2_cnt", 32'(rev_cnt), 2);
        check("rev2_idx", 32'(idx), 0);

        // Error 2: skip 1000 from idx 0.
        step(4'b0100);
        check("e2_err", 32'(err), 1);
        check("e2_err_cnt", 32'(err_cnt), 2);
        check("e2_locked", 32'(locked), 0);
        check("e2_idx", 32'(idx), 0);
        step(4'b0010);
        check("rl2_a_err", 32'(err), 0);
        step(4'b0001);
        step(4'b1000);
        check("rl2_c_locked", 32'(locked), 0);
        step(4'b0100);
        check("rl2_locked", 32'(locked), 1);
        check("rl2_idx", 32'(idx), 2);

        // Error 3: all-zero sample at idx 2.
        step(4'b0000);
        check("e3_err_cnt", 32'(err_cnt), 3);
        check("e3_idx", 32'(idx), 2);

        // Unexpected index in SYNC restarts the count without error.
        step(4'b0001);
        step(4'b0100);
        check_state("sync_skip_state", SYNC);
        check("sync_skip_idx", 32'(idx), 2);
        check("sync_skip_err", 32'(err), 0);
        step(4'b0010);
        step(4'b0001);
        step(4'b1000);
        check("rl3_locked", 32'(locked), 1);
        check("rl3_idx", 32'(idx), 3);

        // Error 4: err_cnt saturates.
        step(4'b1100);
        check("e4_err", 32'(err), 1);
        check("e4_err_cnt", 32'(err_cnt), 3);

        // Non-one-hot in SYNC drops back to HUNT without error.
        step(4'b0001);
        step(4'b0000);
        check_state("sync_drop_state", HUNT);
        check("sync_drop_err", 32'(err), 0);

        // Entering LOCKED on index 0 does not count a revolution.
        step(4'b1000);
        step(4'b0100);
        step(4'b0010);
        step(4'b0001);
        check("lock0_locked", 32'(locked), 1);
        check("lock0_rev_pulse", 32'(rev_pulse), 0);
        check("lock0_rev_cnt", 32'(rev_cnt), 2);

        // Reset wins over a valid sample mid-LOCKED.
        rstn     = 1'b0;
        ring_in  = 4'b1000;
        ring_vld = 1'b1;
        @(posedge clk);
        #1;
        ring_vld = 1'b0;
        rstn     = 1'b1;
        check("mr_idx", 32'(idx), 0);
        check("mr_locked", 32'(locked), 0);
        check("mr_err", 32'(err), 0);
        check("mr_err_cnt", 32'(err_cnt), 0);
        check("mr_rev_pulse", 32'(rev_pulse), 0);
        check("mr_rev_cnt", 32'(rev_cnt), 0);
        check_state("mr_state", HUNT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ring_decoder

// File: doc/ring_decoder.md
RING_DECODER -- requirements
Module: ring_decoder

Interface
REQ-001 SHALL have parameter N, default 4, meaning ring width in bits; legal range N >= 2.
REQ-002 SHALL have parameter LOCK_CNT, default 3, meaning consecutive correct rotation steps required to lock; legal range >= 1.
REQ-003 SHALL have parameter REV_W, default 8, meaning revolution counter width.
REQ-004 SHALL have parameter ERR_W, default 4, meaning error counter width.
REQ-005 SHALL have port clk, input, 1 bit, rising-edge system clock.
REQ-006 SHALL have port rstn, input, 1 bit, synchronous active-low reset.
REQ-007 SHALL have port ring_in, input, N bits, sampled ring pattern.
REQ-008 SHALL have port ring_vld, input, 1 bit, ring_in qualifier.
REQ-009 SHALL have port idx, output, $clog2(N) bits, binary position of the last one-hot sample.
REQ-010 SHALL have port locked, output, 1 bit, high while the FSM is in LOCKED.
REQ-011 SHALL have port err, output, 1 bit, one-cycle pulse on loss of lock.
REQ-012 SHALL have port err_cnt, output, ERR_W bits, saturating count of err pulses.
REQ-013 SHALL have port rev_pulse, output, 1 bit, one-cycle pulse per completed revolution.
REQ-014 SHALL have port rev_cnt, output, REV_W bits, wrapping revolution count.

Function
REQ-015 SHALL treat a sample as one-hot when exactly one bit of ring_in is set; its index k is the position of that bit.
REQ-016 SHALL expect rotation toward lower bit positions: after index k, the expected next index is (k+N-1) mod N (0001 -> 1000 -> 0100 -> 0010 -> 0001 for N=4).
REQ-017 SHALL update all outputs on the clock edge that samples ring_vld=1 (registered, visible the following cycle); with ring_vld=0 all state and outputs hold, except that err and rev_pulse are 0.
REQ-018 SHALL implement FSM states HUNT, SYNC and LOCKED, plus a good-step counter of width $clog2(LOCK_CNT+1).
REQ-019 In HUNT: a one-hot sample moves the FSM to SYNC, loads idx, and clears the good-step counter; a non-one-hot sample stays in HUNT without asserting err.
REQ-020 In SYNC: a one-hot sample at the expected index increments the good-step counter and loads idx; when the counter reaches LOCK_CNT, the FSM moves to LOCKED.
REQ-021 In SYNC: a one-hot sample at an unexpected index stays in SYNC, loads the new idx, and clears the counter; a non-one-hot sample moves the FSM to HUNT; neither case asserts err.
REQ-022 In LOCKED: a sample at the expected index loads idx and stays in LOCKED.
REQ-023 In LOCKED: a non-one-hot or out-of-sequence sample asserts err for one cycle, increments err_cnt saturating at 2^ERR_W-1, moves the FSM to HUNT, and leaves idx unchanged.
REQ-024 In LOCKED: a correct step into index 0 asserts rev_pulse for one cycle and increments rev_cnt modulo 2^REV_W.
REQ-025 SHALL not assert rev_pulse on the step that enters LOCKED, even if that step lands on index 0.
REQ-026 SHALL impose no timeout: arbitrarily long ring_vld gaps do not affect lock.

Reset
REQ-027 With rstn=0 at a rising clk edge, the block SHALL enter HUNT and clear idx, locked, err, err_cnt, rev_pulse, rev_cnt and the good-step counter.
REQ-028 Reset SHALL take priority over ring_vld in the same cycle, including mid-LOCKED.

Structure
REQ-029 Package ring_pkg SHALL hold the FSM state enum (HUNT, SYNC, LOCKED) and a next-index function; the ring counter and this decoder share it.
REQ-030 Combinational sub-module ring_onehot_enc SHALL take N bits and produce is_onehot and a binary index; all state SHALL reside in ring_decoder.

Verification (N=4, LOCK_CNT=3, ERR_W=2)
REQ-031 Reset, then ring_vld=1 with 0001, 1000, 0100, 0010 -> locked=1 the cycle after 0010; a following 0001 -> rev_pulse=1, rev_cnt=1, idx=0.
REQ-032 While locked at idx=3, inject 0011 -> err pulses once, err_cnt=1, locked=0, idx stays 3, FSM in HUNT.
REQ-033 While locked at idx=0, inject 0100 (skipping 1000) -> err=1, locked=0; continue 0010, 0001, 1000, 0100 -> relocks after three correct steps.
REQ-034 While locked, hold ring_vld=0 for 50 cycles between samples -> no err, locked stays 1, outputs frozen.
REQ-035 Force four loss-of-lock errors -> err_cnt reads 1, 2, 3, 3 (saturated).
REQ-036 Apply rstn=0 with ring_vld=1 mid-LOCKED -> all outputs 0 next cycle, FSM in HUNT, err_cnt and rev_cnt cleared.
